i2c_slave: RTL
==============

Name: i2c_slave

Overview:
- Target-side (responder) end of the team's I2C link; pairs with the existing I2C master on the same SCL/SDA wires.
- Oversamples SCL/SDA on the system clock and detects START, repeated START and STOP.
- Matches a fixed 7-bit own address, ACKs it, then either receives write bytes or transmits read bytes from the local user interface.
- SDA is open-drain: only ever driven low or released.

Parameters:
- Data_width, 8, bits per data byte (protocol fixes 8; parameter kept for consistency).
- Address, 7, slave address width.
- Own_addr, 7'h50, address this slave responds to.

Ports:
- clk  input  1  system clock; must be at least 8x the SCL rate.
- rst  input  1  asynchronous, active-high reset.
- scl  input  1  I2C serial clock from the master.
- sda  inout  1  I2C data line; driven 1'b0 when pulling low, else 1'bz.
- i_slave_txdata  input  Data_width  byte returned on the next read; sampled when o_slave_tx_req pulses.
- o_slave_rxdata  output  Data_width  last byte received from the master.
- o_slave_rx_valid  output  1  one-cycle pulse when o_slave_rxdata updates.
- o_slave_tx_req  output  1  one-cycle pulse on the cycle i_slave_txdata is captured.
- o_slave_busy  output  1  high while addressed (from address match until STOP or restart).
- o_slave_done  output  1  one-cycle pulse on STOP ending a transaction that addressed this slave.

Behaviour:
- Reset (async, rst=1):
  - sda released; all outputs 0; state IDLE.
  - Synchronizer flops reset to 1 (idle bus).
- Input conditioning:
  - scl and sda each pass through a 2-flop synchronizer plus a delayed copy.
  - Edges are computed on the synchronized values.
  - Latency from pin to event is 3 clk cycles.
- Bus events:
  - START: sda falls while scl is high.
  - STOP: sda rises while scl is high.
  - Samples are taken on scl rising; SDA changes are made on scl falling.
- States: IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, WAIT_STOP.
- IDLE: START -> ADDR with bit counter = 7.
- ADDR:
  - Shift in 8 bits (7 address bits then R/W) on scl rising.
  - After the 8th bit: if the address matches Own_addr, go to ADDR_ACK and set busy; otherwise go to WAIT_STOP and never drive sda.
- ADDR_ACK:
  - On the next scl falling edge, drive sda low.
  - On the falling edge after the 9th clock:
    - W=0: release sda -> RX.
    - R=1: pulse tx_req, capture i_slave_txdata, drive its MSB -> TX.
- RX:
  - Shift 8 bits on scl rising.
  - On the 8th bit, update rxdata and pulse rx_valid in the same cycle -> RX_ACK.
- RX_ACK: drive sda low for the 9th clock (falling to falling), then release -> RX.
- TX:
  - On each scl falling edge, drive 0 for a 0 bit and release for a 1 bit.
  - After the 8th bit, release sda at the next falling edge -> TX_ACK.
- TX_ACK: sample sda on the 9th scl rising edge.
  - 0 (ACK): at the following falling edge, pulse tx_req, load the next byte -> TX.
  - 1 (NACK): -> WAIT_STOP with sda released.
- WAIT_STOP: ignore traffic until START or STOP.
- STOP in any state:
  - -> IDLE, release sda, clear busy.
  - Pulse done if busy was high.
- Repeated START in any state: release sda, -> ADDR; busy stays high until the address phase is resolved.
- A STOP or START arriving mid-byte discards the partial byte; no rx_valid pulse.
- sda is never driven while scl is high, except when holding an ACK or data bit stable across the high phase.

Optional Feature:
- Macro: I2C_SLAVE_GENERAL_CALL_EN.
- Defined:
  - Address byte 8'h00 (general call, write) is ACKed and proceeds as a write transaction.
  - General-call address with R=1 is NACKed -> WAIT_STOP.
- Undefined: address 0 is treated as a non-matching address.

Decomposition:
- Shared package i2c_pkg holds:
  - state enum encoding;
  - GEN_CALL_ADDR = 7'h00;
  - SDA_RELEASE / SDA_LOW constants.
- Sub-module i2c_bus_sync contains the synchronizers and edge detection.
  - Outputs: scl_rise, scl_fall, start_det, stop_det, sda_s.
  - Reusable by a future bus monitor.

Test Plan:
- Write 0x50 with R/W=0, then data 0xA5, then STOP -> ACK on the 9th clock of both bytes; rxdata=0xA5 with one rx_valid pulse; done pulses once.
- Read 0x50 with R/W=1, i_slave_txdata=0x3C, master NACK -> bits 0,0,1,1,1,1,0,0 appear on sda; one tx_req pulse; sda released after the NACK.
- Address 0x51 with R/W=0 -> no ACK (sda stays high on the 9th clock); busy stays 0; no done on STOP.
- Write 0x50, byte 0x11, repeated START, read 0x50 with txdata=0x77 -> rx_valid with 0x11; busy held high; 0x77 transmitted; done only after the final STOP.
- STOP injected after 4 data bits, and separately rst asserted mid-byte -> state returns to IDLE; no rx_valid; sda released immediately.
- Macro defined: address 0x00 with W=0, data 0x9E -> ACKed and rxdata=0x9E. Macro undefined: same stimulus -> NACK.

Source files
------------

// File: rtl/i2c_pkg.sv
// Types and constants shared by the I2C slave and its bus-conditioning helper.
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_RX,
        ST_RX_ACK,
        ST_TX,
        ST_TX_ACK,
        ST_WAIT_STOP
    } state_t;

    localparam logic [6:0] GEN_CALL_ADDR = 7'h00;

    // Values of the open-drain pull-down enable.
    localparam logic SDA_RELEASE = 1'b0;
    localparam logic SDA_LOW     = 1'b1;

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronizes SCL/SDA into the clk domain and flags SCL edges plus START/STOP.
// Pin-to-event latency is two flops; consumers register the event on the third edge.
module i2c_bus_sync
    import i2c_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic scl,
    input  logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_s
);

    // [1:0] form the synchronizer, [2] is the delayed copy used for edges.
    logic [2:0] scl_q;
    logic [2:0] sda_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_q <= '1;
            sda_q <= '1;
        end else begin
            scl_q <= {scl_q[1:0], scl};
            sda_q <= {sda_q[1:0], sda};
        end
    end

    assign scl_rise  =  scl_q[1] & ~scl_q[2];
    assign scl_fall  = ~scl_q[1] &  scl_q[2];
    assign start_det =  scl_q[1] &  scl_q[2] &  sda_q[2] & ~sda_q[1];
    assign stop_det  =  scl_q[1] &  scl_q[2] & ~sda_q[2] &  sda_q[1];
    assign sda_s     =  sda_q[1];

endmodule

// File: rtl/i2c_slave.sv
// I2C target: address match, write receive and read transmit over open-drain SDA.
// Define I2C_SLAVE_GENERAL_CALL_EN to also accept the general-call write address.
//
// state        | meaning
// IDLE         | bus free or not yet started
// ADDR         | shifting in 7 address bits + R/W
// ADDR_ACK     | driving ACK for our address
// RX           | shifting in a write byte
// RX_ACK       | driving ACK for a received byte
// TX           | driving out a read byte
// TX_ACK       | sampling master ACK/NACK
// WAIT_STOP    | not addressed / NACKed, ignoring traffic
module i2c_slave
    import i2c_pkg::*;
#(
    parameter int                 Data_width = 8,
    parameter int                 Address    = 7,
    parameter logic [Address-1:0] Own_addr   = 7'h50
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  scl,
    inout  wire                   sda,
    input  logic [Data_width-1:0] i_slave_txdata,
    output logic [Data_width-1:0] o_slave_rxdata,
    output logic                  o_slave_rx_valid,
    output logic                  o_slave_tx_req,
    output logic                  o_slave_busy,
    output logic                  o_slave_done
);

    localparam int               CNT_W     = $clog2(Data_width);
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(Address);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(Data_width - 1);

    state_t                state;
    logic [CNT_W-1:0]      bit_cnt;
    logic [Data_width-2:0] shreg;
    logic [Data_width-1:0] txshift;
    logic                  rw;
    logic                  ack_on;
    logic                  sda_pull;
    logic                  addr_hit;

    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;
    logic sda_s;

    i2c_bus_sync u_bus_sync (
        .clk       (clk),
        .rst       (rst),
        .scl       (scl),
        .sda       (sda),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det),
        .sda_s     (sda_s)
    );

    assign sda = (sda_pull == SDA_LOW) ? 1'b0 : 1'bz;

    // Evaluated on the 8th address clock, when sda_s carries the R/W bit.
    always_comb begin
        addr_hit = (shreg[Address-1:0] == Own_addr);
`ifdef I2C_SLAVE_GENERAL_CALL_EN
        if (shreg[Address-1:0] == GEN_CALL_ADDR && !sda_s) begin
            addr_hit = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= ST_IDLE;
            bit_cnt          <= '0;
            shreg            <= '0;
            txshift          <= '0;
            rw               <= 1'b0;
            ack_on           <= 1'b0;
            sda_pull         <= SDA_RELEASE;
            o_slave_rxdata   <= '0;
            o_slave_rx_valid <= 1'b0;
            o_slave_tx_req   <= 1'b0;
            o_slave_busy     <= 1'b0;
            o_slave_done     <= 1'b0;
        end else begin
            o_slave_rx_valid <= 1'b0;
            o_slave_tx_req   <= 1'b0;
            o_slave_done     <= 1'b0;

            if (stop_det) begin
                state        <= ST_IDLE;
                sda_pull     <= SDA_RELEASE;
                o_slave_busy <= 1'b0;
                o_slave_done <= o_slave_busy;
            end else if (start_det) begin
                state    <= ST_ADDR;
                bit_cnt  <= ADDR_LAST;
                sda_pull <= SDA_RELEASE;
            end else begin
                case (state)
                    ST_IDLE: begin
                    end

                    ST_ADDR: begin
                        if (scl_rise) begin
                            shreg <= {shreg[Data_width-3:0], sda_s};
                            if (bit_cnt == '0) begin
                                rw     <= sda_s;
                                ack_on <= 1'b0;
                                if (addr_hit) begin
                                    state        <= ST_ADDR_ACK;
                                    o_slave_busy <= 1'b1;
                                end else begin
                                    state        <= ST_WAIT_STOP;
                                    o_slave_busy <= 1'b0;
                                end
                            end else begin
                                bit_cnt <= bit_cnt - 1'b1;
                            end
                        end
                    end

                    // First falling edge starts the ACK, second one ends it.
                    ST_ADDR_ACK, ST_RX_ACK: begin
                        if (scl_fall) begin
                            if (!ack_on) begin
                                sda_pull <= SDA_LOW;
                                ack_on   <= 1'b1;
                            end else if (state == ST_ADDR_ACK && rw) begin
                                o_slave_tx_req <= 1'b1;
                                txshift  <= {i_slave_txdata[Data_width-2:0], 1'b0};
                                sda_pull <= i_slave_txdata[Data_width-1] ? SDA_RELEASE : SDA_LOW;
                                bit_cnt  <= DATA_LAST;
                                state    <= ST_TX;
                            end else begin
                                sda_pull <= SDA_RELEASE;
                                bit_cnt  <= DATA_LAST;
                                state    <= ST_RX;
                            end
                        end
                    end

                    ST_RX: begin
                        if (scl_rise) begin
                            shreg <= {shreg[Data_width-3:0], sda_s};
                            if (bit_cnt == '0) begin
                                o_slave_rxdata   <= {shreg, sda_s};
                                o_slave_rx_valid <= 1'b1;
                                ack_on           <= 1'b0;
                                state            <= ST_RX_ACK;
                            end else begin
                                bit_cnt <= bit_cnt - 1'b1;
                            end
                        end
                    end

                    // txshift holds the bits still to be sent, MSB first.
                    ST_TX: begin
                        if (scl_fall) begin
                            if (bit_cnt == '0) begin
                                sda_pull <= SDA_RELEASE;
                                ack_on   <= 1'b0;
                                state    <= ST_TX_ACK;
                            end else begin
                                sda_pull <= txshift[Data_width-1] ? SDA_RELEASE : SDA_LOW;
                                txshift  <= {txshift[Data_width-2:0], 1'b0};
                                bit_cnt  <= bit_cnt - 1'b1;
                            end
                        end
                    end

                    ST_TX_ACK: begin
                        if (scl_rise) begin
                            if (sda_s) begin
                                state <= ST_WAIT_STOP;
                            end else begin
                                ack_on <= 1'b1;
                            end
                        end else if (scl_fall && ack_on) begin
                            o_slave_tx_req <= 1'b1;
                            txshift  <= {i_slave_txdata[Data_width-2:0], 1'b0};
                            sda_pull <= i_slave_txdata[Data_width-1] ? SDA_RELEASE : SDA_LOW;
                            bit_cnt  <= DATA_LAST;
                            state    <= ST_TX;
                        end
                    end

                    ST_WAIT_STOP: begin
                    end

                    default: begin
                        state    <= ST_IDLE;
                        sda_pull <= SDA_RELEASE;
                    end
                endcase
            end
        end
    end

endmodule
